// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with a modulus, synchronous load, count enable
// and a wrap or saturate policy at the count boundaries. It also raises a
// terminal-count flag, a one-cycle boundary pulse and a sticky boundary flag.
//
// Parameters
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   highest count value; counting is modulo MAX_VAL+1
//   SATURATE  0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   clk       rising-edge clock
//   clear     asynchronous active-high clear of all state
//   en        count enable
//   up_dn     direction, 1 = up, 0 = down
//   load      synchronous load strobe; has priority over en
//   load_val  value to load; values above MAX_VAL clamp to MAX_VAL
//   count     current count (registered)
//   tc        terminal count: the next edge is a boundary event (combinational)
//   wrap      one-cycle pulse after each boundary event (registered)
//   ovf       sticky boundary-event flag, cleared by clear or load (registered)
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Values the counter moves to when a boundary edge is reached.
    localparam logic [WIDTH-1:0] UP_BOUND_NXT = SATURATE ? MAX_VAL : ZERO;
    localparam logic [WIDTH-1:0] DN_BOUND_NXT = SATURATE ? ZERO    : MAX_VAL;

    logic             at_max;
    logic             at_zero;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;

    // Boundary detection; an event only happens on a real count cycle.
    assign at_max   = (count == MAX_VAL);
    assign at_zero  = (count == ZERO);
    assign boundary = en & ~load & (up_dn ? at_max : at_zero);
    assign tc       = boundary;

    // Out-of-range loads clamp so count never exceeds MAX_VAL.
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Next-state: load > en > hold. The +1/-1 paths are only taken away
    // from the boundaries, so they never leave the 0..MAX_VAL range.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf;
        if (load) begin
            count_nxt = load_clamped;
            ovf_nxt   = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                count_nxt = at_max ? UP_BOUND_NXT : count + ONE;
            end else begin
                count_nxt = at_zero ? DN_BOUND_NXT : count - ONE;
            end
            if (boundary) begin
                wrap_nxt = 1'b1;
                ovf_nxt  = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= ZERO;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Structural invariants of the counter.
    a_count_range : assert property (@(posedge clk) disable iff (clear)
        count <= MAX_VAL);
    a_wrap_sets_ovf : assert property (@(posedge clk) disable iff (clear)
        wrap |-> ovf);

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    logic clk;
    logic clear;

    // Instance a: WIDTH=4, default MAX_VAL (15), wrap
    logic       en_a, up_a, load_a;
    logic [3:0] lv_a, cnt_a;
    logic       tc_a, wrap_a, ovf_a;
    // Instance b: WIDTH=4, MAX_VAL=9, wrap
    logic       en_b, up_b, load_b;
    logic [3:0] lv_b, cnt_b;
    logic       tc_b, wrap_b, ovf_b;
    // Instance c: WIDTH=4, MAX_VAL=9, saturate
    logic       en_c, up_c, load_c;
    logic [3:0] lv_c, cnt_c;
    logic       tc_c, wrap_c, ovf_c;

    int n_checks;
    int n_errors;

    param_updown_counter #(.WIDTH(4)) u_a (
        .clk(clk), .clear(clear), .en(en_a), .up_dn(up_a), .load(load_a),
        .load_val(lv_a), .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_b (
        .clk(clk), .clear(clear), .en(en_b), .up_dn(up_b), .load(load_b),
        .load_val(lv_b), .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_c (
        .clk(clk), .clear(clear), .en(en_c), .up_dn(up_c), .load(load_c),
        .load_val(lv_c), .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        n_checks = 0;
        n_errors = 0;
        clear  = 1'b0;
        en_a = 0; up_a = 1; load_a = 0; lv_a = 0;
        en_b = 0; up_b = 1; load_b = 0; lv_b = 0;
        en_c = 0; up_c = 1; load_c = 0; lv_c = 0;

        // Reset state
        #1 clear = 1'b1;
        #1;
        check("rst_cnt_a", 32'(cnt_a), 0);
        check("rst_wrap_a", 32'(wrap_a), 0);
        check("rst_ovf_a", 32'(ovf_a), 0);
        check("rst_cnt_b", 32'(cnt_b), 0);
        check("rst_cnt_c", 32'(cnt_c), 0);
        #1 clear = 1'b0;

        // Test A: up count through the 15->0 wrap
        en_a = 1; up_a = 1;
        #1;
        check("a_tc_init", 32'(tc_a), 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_cnt = k % 16;
            check($sformatf("a_cnt_%0d", k), 32'(cnt_a), 32'(exp_cnt));
            check($sformatf("a_tc_%0d", k), 32'(tc_a), (exp_cnt == 15) ? 1 : 0);
            check($sformatf("a_wrap_%0d", k), 32'(wrap_a), (k == 16) ? 1 : 0);
            check($sformatf("a_ovf_%0d", k), 32'(ovf_a), (k >= 16) ? 1 : 0);
        end

        // Test B: down count from 0 with MAX_VAL=9, wrapping to 9
        en_a = 0;
        en_b = 1; up_b = 0;
        #1;
        check("b_tc_init", 32'(tc_b), 1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_cnt = (10 - (k % 10)) % 10;
            check($sformatf("b_cnt_%0d", k), 32'(cnt_b), 32'(exp_cnt));
            check($sformatf("b_wrap_%0d", k), 32'(wrap_b), (k == 1 || k == 11) ? 1 : 0);
            check($sformatf("b_ovf_%0d", k), 32'(ovf_b), 1);
        end
        en_b = 0;

        // Test C: saturate mode, load 7 then count up into the ceiling
        load_c = 1; lv_c = 4'd7; en_c = 0;
        tick();
        check("c_load_cnt", 32'(cnt_c), 7);
        check("c_load_ovf", 32'(ovf_c), 0);
        load_c = 0; en_c = 1; up_c = 1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("c_cnt_%0d", k), 32'(cnt_c), (k == 1) ? 8 : 9);
            check($sformatf("c_wrap_%0d", k), 32'(wrap_c), (k >= 3) ? 1 : 0);
            check($sformatf("c_ovf_%0d", k), 32'(ovf_c), (k >= 3) ? 1 : 0);
        end
        en_c = 0;
        tick();
        check("c_hold_cnt", 32'(cnt_c), 9);
        check("c_hold_wrap", 32'(wrap_c), 0);
        check("c_hold_ovf", 32'(ovf_c), 1);

        // Test D: load wins over en, out-of-range value clamps, ovf cleared
        load_b = 1; lv_b = 4'd12; en_b = 1; up_b = 1;
        #1;
        check("d_tc_load", 32'(tc_b), 0);
        tick();
        check("d_cnt_clamp", 32'(cnt_b), 9);
        check("d_ovf_clr", 32'(ovf_b), 0);
        check("d_wrap_clr", 32'(wrap_b), 0);
        load_b = 0;
        #1;
        check("d_tc_max", 32'(tc_b), 1);
        tick();
        check("d_cnt_wrap", 32'(cnt_b), 0);
        check("d_wrap", 32'(wrap_b), 1);
        check("d_ovf", 32'(ovf_b), 1);
        en_b = 0;

        // Test E: async clear mid-count on instance a (currently at 1)
        en_a = 1; up_a = 1;
        for (int k = 0; k < 5; k++) tick();
        check("e_cnt_pre", 32'(cnt_a), 6);
        #2 clear = 1'b1;
        #1;
        check("e_clr_cnt", 32'(cnt_a), 0);
        check("e_clr_ovf", 32'(ovf_a), 0);
        check("e_clr_wrap", 32'(wrap_a), 0);
        tick();
        tick();
        check("e_hold_cnt", 32'(cnt_a), 0);
        #2 clear = 1'b0;
        tick();
        check("e_rel_cnt", 32'(cnt_a), 1);

        // Test F: enable low holds and suppresses tc, direction toggling
        load_a = 1; lv_a = 4'd15; en_a = 0;
        tick();
        load_a = 0; en_a = 0; up_a = 1;
        #1;
        check("f_tc_dis_max", 32'(tc_a), 0);
        load_a = 1; lv_a = 4'd5;
        tick();
        load_a = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("f_hold_%0d", k), 32'(cnt_a), 5);
            check($sformatf("f_hold_tc_%0d", k), 32'(tc_a), 0);
        end
        en_a = 1;
        for (int k = 1; k <= 4; k++) begin
            up_a = (k % 2 == 1);
            tick();
            check($sformatf("f_alt_%0d", k), 32'(cnt_a), (k % 2 == 1) ? 6 : 5);
        end
        en_a = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
